// File: rtl/llc_mshr_ctrl_pkg.sv
// rtl/llc_mshr_ctrl_pkg.sv - shared constants and types for the LLC MSHR allocation controller
package llc_mshr_ctrl_pkg;

    localparam int N_MSHR       = 16;
    localparam int MSHR_BITS    = 4;
    localparam int MSHR_BITS_P1 = MSHR_BITS + 1;
    localparam int LLC_SET_BITS = 8;

    typedef logic [MSHR_BITS-1:0]    mshr_id_t;
    typedef logic [LLC_SET_BITS-1:0] llc_set_t;

endpackage

// File: rtl/llc_mshr_prio_enc.sv
// rtl/llc_mshr_prio_enc.sv - lowest-zero finder over an occupancy bitmap
module llc_mshr_prio_enc #(
    parameter int WIDTH    = 16,
    parameter int IDX_BITS = 4
) (
    input  logic [WIDTH-1:0]    i_vec,
    output logic [IDX_BITS-1:0] o_idx,
    output logic                o_found
);

    // Scanning downward lets the last hit, the lowest free slot, win.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!i_vec[i]) begin
                o_idx   = IDX_BITS'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_mshr_ctrl.sv
// rtl/llc_mshr_ctrl.sv - MSHR entry allocation, retirement, free count and set-conflict queries
module llc_mshr_ctrl
    import llc_mshr_ctrl_pkg::*;
#(
    parameter int N_MSHR_P    = N_MSHR,
    parameter int MSHR_BITS_P = MSHR_BITS,
    parameter int SET_BITS    = LLC_SET_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             alloc_valid,
    input  logic [SET_BITS-1:0]    alloc_set0,
    input  logic [SET_BITS-1:0]    alloc_set1,
    output logic [1:0]             alloc_grant,
    output logic [MSHR_BITS_P-1:0] alloc_id,
    input  logic                   free_valid,
    input  logic [MSHR_BITS_P-1:0] free_id,
    input  logic                   chk_valid,
    input  logic [SET_BITS-1:0]    chk_set,
    output logic                   chk_rsp_valid,
    output logic                   chk_conflict,
    output logic [MSHR_BITS_P:0]   mshr_cnt,
    output logic                   mshr_full,
    output logic                   err_double_free
);

    logic [N_MSHR_P-1:0]    r_valid;
    logic [SET_BITS-1:0]    r_set [N_MSHR_P];
    logic [MSHR_BITS_P:0]   r_cnt;
    logic                   r_full;
    logic                   r_rr;
    logic                   r_chk_rsp_valid;
    logic                   r_chk_conflict;
    logic                   r_err;

    logic [MSHR_BITS_P-1:0] w_idx;
    logic                   w_found;
    logic                   w_can_grant;
    logic [1:0]             w_grant;
    logic                   w_any_grant;
    logic [SET_BITS-1:0]    w_win_set;
    logic                   w_free_ok;
    logic                   w_conflict;
    logic [MSHR_BITS_P:0]   w_cnt_nxt;

    llc_mshr_prio_enc #(
        .WIDTH    (N_MSHR_P),
        .IDX_BITS (MSHR_BITS_P)
    ) u_prio_enc (
        .i_vec   (r_valid),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    // Gating with rst keeps a request from seeing a grant while the bitmap is held clear.
    assign w_can_grant = rst && (r_cnt != '0) && w_found;

    always_comb begin
        w_grant = 2'b00;
        if (w_can_grant) begin
            case (alloc_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_rr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_any_grant = |w_grant;
    assign w_win_set   = w_grant[1] ? alloc_set1 : alloc_set0;
    assign w_free_ok   = free_valid && r_valid[free_id];
    assign w_cnt_nxt   = r_cnt - {{MSHR_BITS_P{1'b0}}, w_any_grant}
                               + {{MSHR_BITS_P{1'b0}}, w_free_ok};

    // Entries retiring this cycle still count, so the stall logic stays conservative.
    always_comb begin
        w_conflict = w_any_grant && (w_win_set == chk_set);
        for (int i = 0; i < N_MSHR_P; i++) begin
            if (r_valid[i] && (r_set[i] == chk_set)) begin
                w_conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid         <= '0;
            for (int i = 0; i < N_MSHR_P; i++) begin
                r_set[i] <= '0;
            end
            r_cnt           <= (MSHR_BITS_P + 1)'(N_MSHR_P);
            r_full          <= 1'b0;
            r_rr            <= 1'b0;
            r_chk_rsp_valid <= 1'b0;
            r_chk_conflict  <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            if (w_free_ok) begin
                r_valid[free_id] <= 1'b0;
            end
            if (w_any_grant) begin
                r_valid[w_idx] <= 1'b1;
                r_set[w_idx]   <= w_win_set;
            end
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == '0);
            if ((alloc_valid == 2'b11) && w_any_grant) begin
                r_rr <= ~r_rr;
            end
            r_chk_rsp_valid <= chk_valid;
            r_chk_conflict  <= w_conflict;
            if (free_valid && !r_valid[free_id]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign alloc_grant     = w_grant;
    assign alloc_id        = w_idx;
    assign chk_rsp_valid   = r_chk_rsp_valid;
    assign chk_conflict    = r_chk_conflict;
    assign mshr_cnt        = r_cnt;
    assign mshr_full       = r_full;
    assign err_double_free = r_err;

endmodule

// File: tb/tb_llc_mshr_ctrl.sv
// tb/tb_llc_mshr_ctrl.sv - directed self-checking bench for llc_mshr_ctrl
module tb_llc_mshr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] alloc_valid = 2'b00;
    logic [7:0] alloc_set0 = 8'h00;
    logic [7:0] alloc_set1 = 8'h00;
    logic [1:0] alloc_grant;
    logic [3:0] alloc_id;
    logic       free_valid = 1'b0;
    logic [3:0] free_id = 4'h0;
    logic       chk_valid = 1'b0;
    logic [7:0] chk_set = 8'h00;
    logic       chk_rsp_valid;
    logic       chk_conflict;
    logic [4:0] mshr_cnt;
    logic       mshr_full;
    logic       err_double_free;

    int n_cmp = 0;
    int n_err = 0;

    llc_mshr_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_set0      (alloc_set0),
        .alloc_set1      (alloc_set1),
        .alloc_grant     (alloc_grant),
        .alloc_id        (alloc_id),
        .free_valid      (free_valid),
        .free_id         (free_id),
        .chk_valid       (chk_valid),
        .chk_set         (chk_set),
        .chk_rsp_valid   (chk_rsp_valid),
        .chk_conflict    (chk_conflict),
        .mshr_cnt        (mshr_cnt),
        .mshr_full       (mshr_full),
        .err_double_free (err_double_free)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) post_edge();
        check("rst_cnt", 32'(mshr_cnt), 32'd16);
        check("rst_full", 32'(mshr_full), 32'd0);
        check("rst_grant", 32'(alloc_grant), 32'd0);
        check("rst_err", 32'(err_double_free), 32'd0);
        check("rst_rsp", 32'(chk_rsp_valid), 32'd0);

        // Fill all 16 entries from requester 0.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            alloc_valid = 2'b01;
            alloc_set0  = 8'h05;
            #1;
            check($sformatf("fill_grant%0d", i), 32'(alloc_grant), 32'd1);
            check($sformatf("fill_id%0d", i), 32'(alloc_id), 32'(i));
            post_edge();
            check($sformatf("fill_cnt%0d", i), 32'(mshr_cnt), 32'(15 - i));
        end
        check("fill_full", 32'(mshr_full), 32'd1);
        @(negedge clk);
        #1;
        check("req17_nogrant", 32'(alloc_grant), 32'd0);

        // Free 7 while full and requesting: no same-cycle grant.
        free_valid = 1'b1;
        free_id    = 4'd7;
        #1;
        check("fa_nogrant", 32'(alloc_grant), 32'd0);
        post_edge();
        check("fa_cnt1", 32'(mshr_cnt), 32'd1);
        check("fa_full0", 32'(mshr_full), 32'd0);
        @(negedge clk);
        free_valid = 1'b0;
        #1;
        check("fa_grant", 32'(alloc_grant), 32'd1);
        check("fa_id7", 32'(alloc_id), 32'd7);
        post_edge();
        check("fa_cnt0", 32'(mshr_cnt), 32'd0);
        check("fa_full1", 32'(mshr_full), 32'd1);

        // Retire entries 0..3 to make room for arbitration.
        @(negedge clk);
        alloc_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            free_valid = 1'b1;
            free_id    = 4'(i);
            post_edge();
            @(negedge clk);
        end
        free_valid = 1'b0;
        check("free4_cnt", 32'(mshr_cnt), 32'd4);

        // Both requesters: round-robin starting at requester 0.
        alloc_valid = 2'b11;
        alloc_set0  = 8'h11;
        alloc_set1  = 8'h22;
        #1;
        check("rr0_grant", 32'(alloc_grant), 32'd1);
        check("rr0_id", 32'(alloc_id), 32'd0);
        post_edge();
        @(negedge clk);
        #1;
        check("rr1_grant", 32'(alloc_grant), 32'd2);
        check("rr1_id", 32'(alloc_id), 32'd1);
        post_edge();
        @(negedge clk);
        alloc_set1 = 8'h2A;
        #1;
        check("rr2_grant", 32'(alloc_grant), 32'd1);
        check("rr2_id", 32'(alloc_id), 32'd2);
        post_edge();
        @(negedge clk);
        #1;
        check("rr3_grant", 32'(alloc_grant), 32'd2);
        check("rr3_id", 32'(alloc_id), 32'd3);
        post_edge();
        check("rr_cnt0", 32'(mshr_cnt), 32'd0);
        check("rr_full", 32'(mshr_full), 32'd1);

        // Conflict queries against entry 3 (set 0x2A).
        @(negedge clk);
        alloc_valid = 2'b00;
        chk_valid   = 1'b1;
        chk_set     = 8'h2A;
        post_edge();
        check("q2a_rsp", 32'(chk_rsp_valid), 32'd1);
        check("q2a_hit", 32'(chk_conflict), 32'd1);
        @(negedge clk);
        chk_set = 8'h2B;
        post_edge();
        check("q2b_miss", 32'(chk_conflict), 32'd0);
        @(negedge clk);
        chk_set    = 8'h2A;
        free_valid = 1'b1;
        free_id    = 4'd3;
        post_edge();
        check("qfree_hit", 32'(chk_conflict), 32'd1);
        check("qfree_cnt", 32'(mshr_cnt), 32'd1);
        @(negedge clk);
        free_valid = 1'b0;
        post_edge();
        check("qafter_miss", 32'(chk_conflict), 32'd0);
        @(negedge clk);
        alloc_valid = 2'b01;
        alloc_set0  = 8'h33;
        chk_set     = 8'h33;
        #1;
        check("qgrant_id", 32'(alloc_id), 32'd3);
        post_edge();
        check("qgrant_hit", 32'(chk_conflict), 32'd1);
        check("qgrant_cnt", 32'(mshr_cnt), 32'd0);
        @(negedge clk);
        alloc_valid = 2'b00;
        chk_valid   = 1'b0;
        post_edge();
        check("qidle_rsp", 32'(chk_rsp_valid), 32'd0);

        // Double free of entry 9.
        @(negedge clk);
        free_valid = 1'b1;
        free_id    = 4'd9;
        post_edge();
        check("df_first_cnt", 32'(mshr_cnt), 32'd1);
        check("df_first_err", 32'(err_double_free), 32'd0);
        @(negedge clk);
        post_edge();
        check("df_cnt", 32'(mshr_cnt), 32'd1);
        check("df_err", 32'(err_double_free), 32'd1);
        @(negedge clk);
        free_valid  = 1'b0;
        alloc_valid = 2'b11;
        alloc_set1  = 8'h44;
        #1;
        check("df_rr_grant", 32'(alloc_grant), 32'd1);
        check("df_rr_id", 32'(alloc_id), 32'd9);
        post_edge();
        check("df_err_sticky", 32'(err_double_free), 32'd1);
        check("df_cnt0", 32'(mshr_cnt), 32'd0);
        @(negedge clk);
        alloc_valid = 2'b00;
        free_valid  = 1'b1;
        free_id     = 4'd4;
        post_edge();
        check("pre_rst_cnt", 32'(mshr_cnt), 32'd1);

        // Reset mid-traffic with both requesters asserted.
        @(negedge clk);
        free_valid  = 1'b0;
        alloc_valid = 2'b11;
        rst         = 1'b0;
        #1;
        check("mrst_grant", 32'(alloc_grant), 32'd0);
        check("mrst_cnt", 32'(mshr_cnt), 32'd16);
        check("mrst_full", 32'(mshr_full), 32'd0);
        check("mrst_err", 32'(err_double_free), 32'd0);
        check("mrst_rsp", 32'(chk_rsp_valid), 32'd0);
        check("mrst_conf", 32'(chk_conflict), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_grant", 32'(alloc_grant), 32'd1);
        check("post_rst_id", 32'(alloc_id), 32'd0);
        post_edge();
        check("post_rst_cnt", 32'(mshr_cnt), 32'd15);
        @(negedge clk);
        alloc_valid = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
